// File: rtl/car_presence_detector_if.sv
// Signal bundle between the loop-sensor front end and car_presence_detector.
// No valid/ready handshake: sensor_raw is a free-running level and arrival is a one-cycle strobe.
interface car_presence_detector_if #(
   parameter int CNT_W = 8
);
   logic             sensor_raw;
   logic             X;
   logic             arrival;
   logic [CNT_W-1:0] car_count;
   logic [1:0]       state_dbg;

   modport master (
      output sensor_raw,
      input  X,
      input  arrival,
      input  car_count,
      input  state_dbg
   );

   modport slave (
      input  sensor_raw,
      output X,
      output arrival,
      output car_count,
      output state_dbg
   );
endinterface

// File: rtl/car_presence_detector.sv
// Synchronises and debounces the loop sensor into a registered car-present flag,
// bridging short dropouts and counting qualified arrivals (saturating).
module car_presence_detector #(
   parameter int DEBOUNCE = 3,
   parameter int HOLD     = 4,
   parameter int CNT_W    = 8
) (
   input  logic                   clock,
   input  logic                   clear,
   car_presence_detector_if.slave bus
);
   typedef enum logic [1:0] {IDLE, QUALIFY, PRESENT, RELEASE} state_t;

   localparam logic [3:0]       DEB_LAST  = 4'(DEBOUNCE - 1);
   localparam logic [3:0]       HOLD_LAST = 4'(HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic             s1, s2;
   state_t           state;
   logic [3:0]       run;
   logic             x_q, arrival_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_inc;

   assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

   always_ff @(posedge clock) begin
      if (!clear) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         state     <= IDLE;
         run       <= 4'd0;
         x_q       <= 1'b0;
         arrival_q <= 1'b0;
         count_q   <= '0;
      end else begin
         s1        <= bus.sensor_raw;
         s2        <= s1;
         arrival_q <= 1'b0;
         case (state)
            IDLE: begin
               if (s2) begin
                  if (DEBOUNCE == 1) begin
                     state     <= PRESENT;
                     x_q       <= 1'b1;
                     arrival_q <= 1'b1;
                     count_q   <= count_inc;
                  end else begin
                     state <= QUALIFY;
                     run   <= 4'd1;
                  end
               end
            end
            QUALIFY: begin
               // A single low sample throws away the partial qualification.
               if (!s2) begin
                  state <= IDLE;
                  run   <= 4'd0;
               end else if (run == DEB_LAST) begin
                  state     <= PRESENT;
                  run       <= 4'd0;
                  x_q       <= 1'b1;
                  arrival_q <= 1'b1;
                  count_q   <= count_inc;
               end else begin
                  run <= run + 4'd1;
               end
            end
            PRESENT: begin
               if (!s2) begin
                  if (HOLD == 1) begin
                     state <= IDLE;
                     x_q   <= 1'b0;
                  end else begin
                     state <= RELEASE;
                     run   <= 4'd1;
                  end
               end
            end
            RELEASE: begin
               // Sensor returning during the hold is the same car: no arrival.
               if (s2) begin
                  state <= PRESENT;
                  run   <= 4'd0;
               end else if (run == HOLD_LAST) begin
                  state <= IDLE;
                  run   <= 4'd0;
                  x_q   <= 1'b0;
               end else begin
                  run <= run + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               run   <= 4'd0;
               x_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.X         = x_q;
   assign bus.arrival   = arrival_q;
   assign bus.car_count = count_q;
   assign bus.state_dbg = state;
endmodule
